// File: rtl/spi_slave_module.sv
// SPI slave: pins synchronized onto CLK, CPOL/CPHA selectable,
// single-byte TX holding register and RX byte buffer.
module spi_slave_module #(
    parameter logic CLK_FREE_LEVEL = 1'b0,
    parameter logic MODE           = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       PIN_SCK,
    input  logic       PIN_CSN,
    input  logic       PIN_MOSI,
    output logic       PIN_MISO,
    output logic       PIN_MISO_OE,
    input  logic [7:0] SBUF,
    input  logic       Load_Sig,
    output logic       Tx_Empty,
    output logic [7:0] RBUF,
    output logic       Dat_Rdy_Sig,
    output logic       Busy_Flg,
    output logic       Udr_Flg
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  sck_sync;
    logic [2:0]  csn_sync;
    logic [1:0]  mosi_sync;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [7:0]  hold;
    logic        start;
    logic        run;
    logic        lead_edge;
    logic        trail_edge;
    logic        sample_edge;
    logic        shift_edge;
    logic        csn_fall;
    logic        csn_rise;
    logic        byte_done;
    logic        reload;
    logic        tx_shift_en;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sck_sync  <= {3{CLK_FREE_LEVEL}};
            csn_sync  <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], PIN_SCK};
            csn_sync  <= {csn_sync[1:0], PIN_CSN};
            mosi_sync <= {mosi_sync[0], PIN_MOSI};
        end
    end

    assign lead_edge   = (sck_sync[2] == CLK_FREE_LEVEL) &&
                         (sck_sync[1] != CLK_FREE_LEVEL);
    assign trail_edge  = (sck_sync[2] != CLK_FREE_LEVEL) &&
                         (sck_sync[1] == CLK_FREE_LEVEL);
    assign sample_edge = MODE ? trail_edge : lead_edge;
    assign shift_edge  = MODE ? lead_edge : trail_edge;
    assign csn_fall    = csn_sync[2] & ~csn_sync[1];
    assign csn_rise    = ~csn_sync[2] & csn_sync[1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        run       = 1'b0;
        unique case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_nxt = ACTIVE;
                    start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_rise) state_nxt = IDLE;
                else          run       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter 0 marks a byte boundary: MODE 0 reloads on the trailing
    // edge there, MODE 1 holds the freshly reloaded bit 7 for that edge.
    assign byte_done   = run & sample_edge & (bit_cnt == 3'd7);
    assign reload      = start |
                         (MODE ? byte_done
                               : (run & shift_edge & (bit_cnt == 3'd0)));
    assign tx_shift_en = run & shift_edge & (bit_cnt != 3'd0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'hFF;
            hold        <= 8'h00;
            RBUF        <= 8'h00;
            Dat_Rdy_Sig <= 1'b0;
            Tx_Empty    <= 1'b1;
            Udr_Flg     <= 1'b0;
        end else begin
            Dat_Rdy_Sig <= 1'b0;
            if (Load_Sig && !reload) begin
                hold     <= SBUF;
                Tx_Empty <= 1'b0;
            end
            if (start) begin
                bit_cnt <= 3'd0;
                Udr_Flg <= 1'b0;
            end
            // A load arriving with the reload bypasses the holding register.
            if (reload) begin
                if (Load_Sig) begin
                    tx_shift <= SBUF;
                    Tx_Empty <= 1'b1;
                end else if (!Tx_Empty) begin
                    tx_shift <= hold;
                    Tx_Empty <= 1'b1;
                end else begin
                    tx_shift <= 8'hFF;
                    Udr_Flg  <= 1'b1;
                end
            end else if (tx_shift_en) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
            if (run && sample_edge) begin
                rx_shift <= {rx_shift[6:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    RBUF        <= {rx_shift[6:0], mosi_sync[1]};
                    Dat_Rdy_Sig <= 1'b1;
                end
            end
        end
    end

    assign Busy_Flg    = (state == ACTIVE);
    assign PIN_MISO    = tx_shift[7];
    assign PIN_MISO_OE = ~csn_sync[1];

endmodule
